// File: rtl/vx_tcu_tfr_mac_int.sv
// vx_tcu_tfr_mac_int: pipelined integer dot-product unit (I8/U8/I4/U4/MXI8) with per-lane
// saturating K-loop accumulation and one valid/ready result vector per tile.
module vx_tcu_tfr_mac_int #(
    parameter int N = 2,
    parameter int TCK = 2 * N,
    parameter int ACC_W = 32,
    parameter int KCNT_W = 8,
    localparam int TCU_MAX_INPUTS = 4 * TCK
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      valid_in,
    output logic                      ready_in,
    input  logic                      last_in,
    input  logic [2:0]                fmt_i,
    input  logic [TCU_MAX_INPUTS-1:0] vld_mask,
    input  logic [N*32-1:0]           a_row,
    input  logic [N*32-1:0]           b_col,
    input  logic [7:0]                sf_a,
    input  logic [7:0]                sf_b,
    output logic                      valid_out,
    input  logic                      ready_out,
    output logic [TCK*ACC_W-1:0]      result,
    output logic [TCK-1:0]            ovf,
    output logic [KCNT_W-1:0]         k_count
);
    localparam logic [3:0] TCU_I8_ID = 4'd9, TCU_U8_ID = 4'd10, TCU_I4_ID = 4'd11;
    localparam logic [3:0] TCU_U4_ID = 4'd12, TCU_MXI8_ID = 4'd13;
    // Accumulate width leaves headroom over both the accumulator and the 25-bit lane sum.
    localparam int SW = (ACC_W > 25 ? ACC_W : 25) + 2;
    localparam logic signed [SW-1:0] HI_S = {{(SW-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
    localparam logic signed [SW-1:0] LO_S = {{(SW-ACC_W+1){1'b1}}, {(ACC_W-1){1'b0}}};
    localparam logic signed [SW-1:0] HI_U = {{(SW-ACC_W){1'b0}}, {ACC_W{1'b1}}};

    function automatic logic [16:0] mul8(input logic [7:0] a, input logic [7:0] b, input logic s);
        logic signed [17:0] p;
        p = $signed({s & a[7], a}) * $signed({s & b[7], b});
        return 17'(p);
    endfunction

    function automatic logic [16:0] mul4(input logic [3:0] a, input logic [3:0] b, input logic s);
        logic signed [9:0] p;
        p = $signed({s & a[3], a}) * $signed({s & b[3], b});
        return 17'(p);
    endfunction

    // MX scaling: left shifts clip to 25-bit signed, right shifts truncate toward zero.
    function automatic logic [24:0] scale(input logic [16:0] p, input logic [9:0] e);
        logic signed [40:0] w;
        logic signed [17:0] r;
        logic [9:0] n;
        if (!e[9]) begin
            w = 41'($signed(p)) <<< (e > 10'd24 ? 5'd24 : e[4:0]);
            return w > 41'sd16777215 ? 25'h0FFFFFF : w < -41'sd16777216 ? 25'h1000000 : 25'(w);
        end
        n = -e;
        if (n >= 10'd17) return '0;
        r = 18'($signed(p)) + (p[16] ? (18'sd1 <<< n[4:0]) - 18'sd1 : 18'sd0);
        r = r >>> n[4:0];
        return 25'(r);
    endfunction

    logic adv, in_i8, in_i4, in_sgn;
    logic [3:0] id;
    logic [9:0] s1_e_d, s1_e_q;
    logic [TCK-1:0][3:0][16:0] s1_p_d, s1_p_q;
    logic s1_v_q, s1_last_q, s1_sgn_q, s1_mx_q;
    logic [TCK-1:0][24:0] s2_sum_d, s2_sum_q;
    logic s2_v_q, s2_last_q, s2_sgn_q;
    logic signed [SW-1:0] sum, hi, lo;
    logic [TCK-1:0][ACC_W-1:0] acc_d, acc_q, res_q;
    logic [TCK-1:0] ovf_d, ovf_acc_q, ovf_q;
    logic [KCNT_W-1:0] cnt_d, cnt_q, kc_q;
    logic ts_q, vout_q;

    assign adv = !vout_q || ready_out;
    assign ready_in = adv;
    assign valid_out = vout_q;
    assign result = res_q;
    assign ovf = ovf_q;
    assign k_count = kc_q;

    always_comb begin
        id = {1'b1, fmt_i};
        in_i8 = id == TCU_I8_ID || id == TCU_U8_ID || id == TCU_MXI8_ID;
        in_i4 = id == TCU_I4_ID || id == TCU_U4_ID;
        in_sgn = id == TCU_I8_ID || id == TCU_I4_ID || id == TCU_MXI8_ID;
        s1_e_d = {2'b0, sf_a} + {2'b0, sf_b} - 10'd266;
        s1_p_d = '0;
        for (int i = 0; i < TCK; i++) begin
            for (int j = 0; j < 2; j++)
                if (in_i8 && vld_mask[i*4+2*j])
                    s1_p_d[i][j] = mul8(a_row[i*16+8*j +: 8], b_col[i*16+8*j +: 8], in_sgn);
            for (int j = 0; j < 4; j++)
                if (in_i4 && vld_mask[i*4+j])
                    s1_p_d[i][j] = mul4(a_row[i*16+4*j +: 4], b_col[i*16+4*j +: 4], in_sgn);
        end
    end

    always_comb begin
        s2_sum_d = '0;
        for (int i = 0; i < TCK; i++)
            for (int j = 0; j < 4; j++)
                s2_sum_d[i] = s2_sum_d[i] + (s1_mx_q ? scale(s1_p_q[i][j], s1_e_q) : 25'($signed(s1_p_q[i][j])));
    end

    // Saturation bounds follow the signedness of the beat currently in S3.
    always_comb begin
        hi = s2_sgn_q ? HI_S : HI_U;
        lo = s2_sgn_q ? LO_S : '0;
        sum = '0;
        acc_d = '0;
        ovf_d = '0;
        for (int i = 0; i < TCK; i++) begin
            sum = (ts_q ? SW'(0) : s2_sgn_q ? SW'($signed(acc_q[i])) : SW'(acc_q[i])) + SW'($signed(s2_sum_q[i]));
            acc_d[i] = sum > hi ? hi[ACC_W-1:0] : sum < lo ? lo[ACC_W-1:0] : sum[ACC_W-1:0];
            ovf_d[i] = (!ts_q && ovf_acc_q[i]) || sum > hi || sum < lo;
        end
        cnt_d = ts_q ? KCNT_W'(1) : cnt_q + KCNT_W'(cnt_q != '1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            {s1_v_q, s1_last_q, s1_sgn_q, s1_mx_q, s1_e_q, s1_p_q} <= '0;
            {s2_v_q, s2_last_q, s2_sgn_q, s2_sum_q} <= '0;
            {acc_q, ovf_acc_q, cnt_q, res_q, ovf_q, kc_q, vout_q} <= '0;
            ts_q <= 1'b1;
        end else if (adv) begin
            s1_v_q <= valid_in;
            s1_last_q <= valid_in && last_in;
            s1_sgn_q <= in_sgn;
            s1_mx_q <= id == TCU_MXI8_ID;
            s1_e_q <= s1_e_d;
            s1_p_q <= s1_p_d;
            s2_v_q <= s1_v_q;
            s2_last_q <= s1_v_q && s1_last_q;
            s2_sgn_q <= s1_sgn_q;
            s2_sum_q <= s2_sum_d;
            vout_q <= s2_v_q && s2_last_q;
            if (s2_v_q) begin
                acc_q <= acc_d;
                ovf_acc_q <= ovf_d;
                cnt_q <= cnt_d;
                ts_q <= s2_last_q;
                if (s2_last_q) begin
                    res_q <= acc_d;
                    ovf_q <= ovf_d;
                    kc_q <= cnt_d;
                end
            end
        end
    end
endmodule

// File: tb/tb_vx_tcu_tfr_mac_int.sv
// tb_vx_tcu_tfr_mac_int: table-driven tiles with a result scoreboard, run on a 32-bit and a
// 17-bit accumulator instance in lockstep, plus backpressure and mid-tile reset sequences.
module tb_vx_tcu_tfr_mac_int;
    localparam int TCK = 4;
    logic clk = 0, reset_n = 0, valid_in = 0, last_in = 0, ready_out = 1;
    logic [2:0] fmt_i = '0;
    logic [15:0] vld_mask = '0;
    logic [63:0] a_row = '0, b_col = '0;
    logic [7:0] sf_a = '0, sf_b = '0;
    logic ready_in, valid_out, ready_in17, valid_out17;
    logic [TCK*32-1:0] result;
    logic [TCK*17-1:0] result17;
    logic [TCK-1:0] ovf, ovf17;
    logic [7:0] k_count, k_count17;

    vx_tcu_tfr_mac_int #(.N(2), .ACC_W(32), .KCNT_W(8)) dut (
        .clk(clk), .reset_n(reset_n), .valid_in(valid_in), .ready_in(ready_in), .last_in(last_in),
        .fmt_i(fmt_i), .vld_mask(vld_mask), .a_row(a_row), .b_col(b_col), .sf_a(sf_a), .sf_b(sf_b),
        .valid_out(valid_out), .ready_out(ready_out), .result(result), .ovf(ovf), .k_count(k_count));

    vx_tcu_tfr_mac_int #(.N(2), .ACC_W(17), .KCNT_W(8)) dut17 (
        .clk(clk), .reset_n(reset_n), .valid_in(valid_in), .ready_in(ready_in17), .last_in(last_in),
        .fmt_i(fmt_i), .vld_mask(vld_mask), .a_row(a_row), .b_col(b_col), .sf_a(sf_a), .sf_b(sf_b),
        .valid_out(valid_out17), .ready_out(ready_out), .result(result17), .ovf(ovf17), .k_count(k_count17));

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] fmt; logic [15:0] a, b, mask; logic [7:0] sa, sb; int beats;
        longint e32; bit o32; longint e17; bit o17;
    } vec_t;
    typedef struct { longint e32; bit o32; longint e17; bit o17; int k; int t; bit lat; } exp_t;

    exp_t q[$];
    int cyc = 0, n_chk = 0, n_fail = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Scoreboard: every handshaken result is compared against the oldest pushed tile.
    always @(negedge clk) begin
        exp_t e;
        #2;
        if (reset_n && valid_out && ready_out) begin
            if (q.size() == 0) check("unexpected_valid_out", valid_out, 0);
            else begin
                e = q.pop_front();
                check("valid_out17", valid_out17, 1);
                for (int l = 0; l < TCK; l++) begin
                    check("result32", result[l*32 +: 32], e.e32 & 64'hFFFFFFFF);
                    check("result17", result17[l*17 +: 17], e.e17 & 64'h1FFFF);
                end
                check("ovf32", ovf, {TCK{e.o32}});
                check("ovf17", ovf17, {TCK{e.o17}});
                check("k_count", k_count, e.k);
                check("k_count17", k_count17, e.k);
                if (e.lat) check("latency", cyc - e.t, 3);
            end
        end
    end

    task automatic send(input vec_t v, input bit last, input bit lat);
        int g = 0;
        @(negedge clk);
        valid_in = 1; last_in = last; fmt_i = v.fmt; vld_mask = v.mask;
        a_row = {4{v.a}}; b_col = {4{v.b}}; sf_a = v.sa; sf_b = v.sb;
        #1;
        while (!ready_in && g < 100) begin
            @(negedge clk); #1; g++;
        end
        if (!ready_in) check("accept_timeout", ready_in, 1);
        if (last) q.push_back('{v.e32, v.o32, v.e17, v.o17, v.beats, cyc, lat});
    endtask

    task automatic idle();
        @(negedge clk);
        valid_in = 0; last_in = 0;
    endtask

    task automatic tile(input vec_t v, input bit lat);
        for (int b = 0; b < v.beats; b++) send(v, b == v.beats - 1, lat);
        idle();
    endtask

    task automatic drain();
        int g = 0;
        while (q.size() != 0 && g < 50) begin
            @(negedge clk); g++;
        end
        check("drain_timeout", q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t vt[12];
        vec_t va, vb, vc;
        vt[0]  = '{3'd1, 16'h7F7F, 16'h7F7F, 16'hFFFF, 8'd133, 8'd133, 4, 129032, 0, 65535, 1};
        vt[1]  = '{3'd3, 16'h8888, 16'h8888, 16'hFFFF, 8'd133, 8'd133, 1, 256, 0, 256, 0};
        vt[2]  = '{3'd3, 16'h8888, 16'h8888, 16'h1111, 8'd133, 8'd133, 1, 64, 0, 64, 0};
        vt[3]  = '{3'd2, 16'hFFFF, 16'hFFFF, 16'hFFFF, 8'd133, 8'd133, 2, 260100, 0, 131071, 1};
        vt[4]  = '{3'd2, 16'hFFFF, 16'hFFFF, 16'hFFFF, 8'd133, 8'd133, 1, 130050, 0, 130050, 0};
        vt[5]  = '{3'd5, 16'hF9F9, 16'h0101, 16'hFFFF, 8'd133, 8'd131, 1, -2, 0, -2, 0};
        vt[6]  = '{3'd5, 16'h0503, 16'h0101, 16'hFFFF, 8'd134, 8'd134, 1, 32, 0, 32, 0};
        vt[7]  = '{3'd5, 16'h7F7F, 16'h7F7F, 16'hFFFF, 8'd116, 8'd133, 1, 0, 0, 0, 0};
        vt[8]  = '{3'd5, 16'h0001, 16'h0001, 16'h1111, 8'd150, 8'd150, 1, 16777215, 0, 65535, 1};
        vt[9]  = '{3'd1, 16'h8080, 16'h7F7F, 16'hFFFF, 8'd133, 8'd133, 3, -97536, 0, -65536, 1};
        vt[10] = '{3'd0, 16'h7F7F, 16'h7F7F, 16'hFFFF, 8'd133, 8'd133, 1, 0, 0, 0, 0};
        vt[11] = '{3'd1, 16'h0201, 16'h0301, 16'h4444, 8'd133, 8'd133, 1, 6, 0, 6, 0};
        va = '{3'd1, 16'h7F7F, 16'h7F7F, 16'hFFFF, 8'd133, 8'd133, 2, 64516, 0, 64516, 0};
        vb = '{3'd4, 16'hFFFF, 16'hFFFF, 16'hFFFF, 8'd133, 8'd133, 1, 900, 0, 900, 0};
        vc = '{3'd2, 16'h0101, 16'h0101, 16'hFFFF, 8'd133, 8'd133, 1, 2, 0, 2, 0};

        repeat (3) @(negedge clk);
        #1;
        check("rst_valid_out", valid_out, 0);
        check("rst_result", result, 0);
        check("rst_ovf", ovf, 0);
        check("rst_k_count", k_count, 0);
        check("rst_ready_in", ready_in, 1);
        @(negedge clk) reset_n = 1;

        foreach (vt[i]) begin
            tile(vt[i], 1);
            drain();
        end

        // Two tiles in flight while the consumer stalls.
        @(negedge clk) ready_out = 0;
        send(va, 0, 0);
        send(va, 1, 0);
        send(vb, 1, 0);
        idle();
        repeat (5) begin
            @(negedge clk); #1;
            check("stall_ready_in", ready_in, 0);
            check("stall_valid_out", valid_out, 1);
            check("stall_result", result[31:0], 64516);
            check("stall_k_count", k_count, 2);
        end
        @(negedge clk) ready_out = 1;
        drain();
        tile(vc, 1);
        drain();

        // Reset in the middle of a tile discards the partial accumulation.
        send(vt[0], 0, 0);
        send(vt[0], 0, 0);
        idle();
        repeat (3) @(negedge clk);
        #3 reset_n = 0;
        #1;
        check("mid_rst_valid_out", valid_out, 0);
        check("mid_rst_result", result, 0);
        check("mid_rst_result17", result17, 0);
        check("mid_rst_k_count", k_count, 0);
        check("mid_rst_ready_in", ready_in, 1);
        @(negedge clk) reset_n = 1;
        tile(vt[1], 1);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
